hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the E-stage operand-forwarding mux selects (forwardAE/forwardBE) and the D-stage branch-compare forwarding selects.
- Generates stall/flush for load-use, branch-operand and multi-cycle mult/div hazards.
- Owns the IDLE/BUSY sequencer of the iterative HI/LO multiply/divide unit.

Parameters:
- REG_AW, 5, register-address width
- MUL_CYCLES, 4, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 32, busy cycles for div/divu (>=1)
- CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rsD, rtD  in  REG_AW  D-stage source registers
- rsE, rtE  in  REG_AW  E-stage source registers
- writeRegE, writeRegM, writeRegW  in  REG_AW  destination register per stage
- regWriteE, regWriteM, regWriteW  in  1  destination write enable per stage
- memToRegE, memToRegM  in  1  stage holds a load
- branchD  in  1  D-stage branch (compare in D)
- mdReqD  in  1  D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
- mdStartE  in  1  valid mult/div in E this cycle (launches unit)
- mdIsDivE  in  1  with mdStartE: 1 = div, 0 = mult
- forwardAE, forwardBE  out  2  00 = RD*E, 01 = ResultW, 10 = ALUOutM
- forwardAD, forwardBD  out  1  1 = use ALUOutM for branch compare
- stallF, stallD  out  1  hold PC / IF-ID register
- flushE  out  1  clear ID-EX register (insert bubble)
- mdBusy  out  1  mult/div unit iterating
- mdDone  out  1  final busy cycle; HI/LO write enable

Behaviour:
- Forwarding (combinational):
  - forwardAE = 10 if regWriteM && writeRegM!=0 && writeRegM==rsE.
  - Otherwise forwardAE = 01 if regWriteW && writeRegW!=0 && writeRegW==rsE.
  - Otherwise forwardAE = 00. M has priority over W.
  - forwardBE: same rules using rtE.
  - Register 0 never forwards.
- forwardAD = regWriteM && writeRegM!=0 && writeRegM==rsD. forwardBD is the same with rtD.
- lwstall = memToRegE && writeRegE!=0 && (writeRegE==rsD || writeRegE==rtD).
- branchstall = branchD && (hitE || hitM):
  - hitE = regWriteE, writeRegE nonzero and equal to rsD or rtD.
  - hitM = memToRegM, writeRegM nonzero and equal to rsD or rtD.
- mdstall = mdReqD && (mdBusy || mdStartE). Covers back-to-back mult/div and mfhi directly after mult.
- stall = lwstall | branchstall | mdstall. stallF = stallD = flushE = stall, same cycle, combinational.
- Sequencer (registered state, cnt):
  - IDLE + mdStartE: next state BUSY; cnt <= (mdIsDivE ? DIV_CYCLES : MUL_CYCLES).
  - BUSY: cnt decrements by 1 each cycle. When cnt==1, mdDone=1 and the next state is IDLE with cnt=0.
  - mdBusy = (state==BUSY). Busy duration is exactly MUL_CYCLES or DIV_CYCLES cycles, starting the cycle after mdStartE.
  - mdStartE while BUSY cannot occur because of mdstall. It is ignored (no reload); the bench asserts it never occurs.
  - mdStartE and mdDone in the same cycle is also illegal and ignored.
- Reset (async, any time including mid-operation): state=IDLE, cnt=0, so mdBusy=0 and mdDone=0 immediately. The in-flight result is discarded (HI/LO not written).
- Combinational outputs follow their inputs during reset. With all-zero inputs, all outputs are 0.
- No combinational path from mdStartE to mdBusy. A path from mdStartE to stall is permitted.

Decomposition:
- Shared package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - md_state_t {MD_IDLE, MD_BUSY}
  - REG_AW default
- One natural sub-module, md_sequencer (FSM + counter; ports clk, rst, mdStartE, mdIsDivE, mdBusy, mdDone).
- Forwarding and stall logic stay in the top.

Test Plan:
- Forwarding priority: rsE=8; regWriteM=1, writeRegM=8; regWriteW=1, writeRegW=8 -> forwardAE=10. Drop regWriteM -> 01. Set writeRegW=0 and rsE=0 -> 00.
- Load-use: memToRegE=1, writeRegE=9, rtD=9 -> stallF=stallD=flushE=1. Next cycle memToRegE=0 with writeRegW=9 -> stall=0, forwardBE=01.
- Branch hazard: branchD=1, rsD=4, regWriteE=1, writeRegE=4 -> stall=1. Next cycle memToRegM=0, regWriteM=1, writeRegM=4 -> stall=0, forwardAD=1.
- Divide timing: mdStartE=1, mdIsDivE=1 at cycle 0 -> mdBusy=1 cycles 1..32, mdDone=1 only in cycle 32, mdBusy=0 at cycle 33. Holding mdReqD=1 -> stall=1 cycles 0..32, 0 at cycle 33.
- Multiply: mdStartE=1, mdIsDivE=0 -> mdBusy cycles 1..4, mdDone at cycle 4.
- Reset mid-operation: start a div, assert rst at cycle 10 between clock edges -> mdBusy=0 and mdDone=0 before the next edge. After release, mdReqD=1 with mdStartE=0 -> stall=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

endpackage

// File: rtl/md_sequencer.sv
// IDLE/BUSY sequencer for the iterative HI/LO multiply/divide unit.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic mdStartE,
    input  logic mdIsDivE,
    output logic mdBusy,
    output logic mdDone
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= MD_IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // A start while busy is ignored: the D-stage stall keeps it from happening.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            MD_IDLE: begin
                if (mdStartE) begin
                    stateD = MD_BUSY;
                    cntD   = mdIsDivE ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                if (cntQ == CNT_ONE) begin
                    stateD = MD_IDLE;
                    cntD   = '0;
                end else begin
                    cntD = cntQ - CNT_ONE;
                end
            end
            default: begin
                stateD = MD_IDLE;
                cntD   = '0;
            end
        endcase
    end

    always_comb begin
        mdBusy = (stateQ == MD_BUSY);
        mdDone = (stateQ == MD_BUSY) && (cntQ == CNT_ONE);
    end

endmodule

// File: rtl/hazard_controller.sv
// Forwarding selects, stall/flush generation and mult/div sequencing for the
// 5-stage MIPS pipeline.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeRegE,
    input  logic [REG_AW-1:0] writeRegM,
    input  logic [REG_AW-1:0] writeRegW,
    input  logic              regWriteE,
    input  logic              regWriteM,
    input  logic              regWriteW,
    input  logic              memToRegE,
    input  logic              memToRegM,
    input  logic              branchD,
    input  logic              mdReqD,
    input  logic              mdStartE,
    input  logic              mdIsDivE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              mdBusy,
    output logic              mdDone
);

    logic wrE, wrM, wrW, ldM;
    logic lwStall, branchStall, mdStall, stall;

    // Register 0 is hard-wired, so a write to it is never a real producer.
    assign wrE = regWriteE && (writeRegE != '0);
    assign wrM = regWriteM && (writeRegM != '0);
    assign wrW = regWriteW && (writeRegW != '0);
    assign ldM = memToRegM && (writeRegM != '0);

    always_comb begin
        forwardAE = FWD_RF;
        if (wrM && (writeRegM == rsE)) begin
            forwardAE = FWD_MEM;
        end else if (wrW && (writeRegW == rsE)) begin
            forwardAE = FWD_WB;
        end

        forwardBE = FWD_RF;
        if (wrM && (writeRegM == rtE)) begin
            forwardBE = FWD_MEM;
        end else if (wrW && (writeRegW == rtE)) begin
            forwardBE = FWD_WB;
        end
    end

    assign forwardAD = wrM && (writeRegM == rsD);
    assign forwardBD = wrM && (writeRegM == rtD);

    assign lwStall = memToRegE && (writeRegE != '0)
                     && ((writeRegE == rsD) || (writeRegE == rtD));

    assign branchStall = branchD
        && ((wrE && ((writeRegE == rsD) || (writeRegE == rtD)))
            || (ldM && ((writeRegM == rsD) || (writeRegM == rtD))));

    assign mdStall = mdReqD && (mdBusy || mdStartE);

    assign stall  = lwStall | branchStall | mdStall;
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

    md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_sequencer (
        .clk      (clk),
        .rst      (rst),
        .mdStartE (mdStartE),
        .mdIsDivE (mdIsDivE),
        .mdBusy   (mdBusy),
        .mdDone   (mdDone)
    );

endmodule
